// File: rtl/inst_fetch_unit.sv
// Fetch stage: holds the PC, issues one word fetch at a time, and presents the
// fetched instruction plus its {funct3, opcode[6:2]} decode pattern to decode.
module inst_fetch_unit #(
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC    = 32'h8000_0000,
  parameter int unsigned          PATTERN_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDR_W-1:0]       imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [31:0]             imem_rsp_data,
  input  logic                    imem_rsp_err,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst,
  output logic [ADDR_W-1:0]       inst_pc,
  output logic [PATTERN_LEN-1:0]  inst_pattern,
  output logic                    fetch_fault
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              redir_ok;

  assign redir_ok = (redirect_pc[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // kill_q marks an outstanding request whose response must be dropped.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_req_ready) begin
            kill_d  = 1'b1;
            state_d = redir_ok ? ST_WAIT : ST_FAULT;
          end else begin
            state_d = redir_ok ? ST_REQ : ST_FAULT;
          end
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d = 1'b0;
            if (redirect_valid) begin
              pc_d    = redirect_pc;
              state_d = redir_ok ? ST_REQ : ST_FAULT;
            end else begin
              state_d = ST_REQ;
            end
          end else if (imem_rsp_err) begin
            state_d = ST_FAULT;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          kill_d  = 1'b1;
          state_d = redir_ok ? ST_WAIT : ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = redir_ok ? ST_REQ : ST_FAULT;
        end else if (inst_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = ST_REQ;
        end
      end
      ST_FAULT: begin
        if (imem_rsp_valid) kill_d = 1'b0;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // A still-pending response must drain before a new request goes out.
          if (!redir_ok)                          state_d = ST_FAULT;
          else if (kill_q && !imem_rsp_valid)     state_d = ST_WAIT;
          else                                    state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == ST_HOLD);
  assign fetch_fault    = (state_q == ST_FAULT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_pattern   = {inst_q[14:12], inst_q[6:2]};

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: drives the memory and decode sides cycle
// by cycle and checks outputs against hand-computed values.
module tb_inst_fetch_unit;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic [7:0]  inst_pattern;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pattern(inst_pattern),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
    step(); step();
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    @(negedge clk); rst = 1'b0;
    step();

    // 1: minimum-latency fetch
    chk("t1_req_valid", imem_req_valid, 1);
    chk("t1_req_addr", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1; step(); imem_req_ready = 0;
    chk("t1_wait_no_req", imem_req_valid, 0);
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0297; step(); imem_rsp_valid = 0;
    chk("t1_inst_valid", inst_valid, 1);
    chk("t1_inst", inst, 32'h0000_0297);
    chk("t1_inst_pc", inst_pc, 32'h8000_0000);
    chk("t1_pattern", inst_pattern, 8'b000_00101);

    // 2: decode stall
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", inst_valid, 1);
      chk("t2_hold_inst", inst, 32'h0000_0297);
      chk("t2_hold_pc", inst_pc, 32'h8000_0000);
      chk("t2_no_req", imem_req_valid, 0);
    end
    inst_ready = 1; step(); inst_ready = 0;
    chk("t2_req_valid", imem_req_valid, 1);
    chk("t2_req_addr", imem_req_addr, 32'h8000_0004);
    chk("t2_consumed", inst_valid, 0);

    // 3: redirect while waiting for a response
    imem_req_ready = 1; step(); imem_req_ready = 0;
    redir(32'h8000_0100);
    chk("t3_still_wait", imem_req_valid, 0);
    step();
    chk("t3_no_inst", inst_valid, 0);
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; step(); imem_rsp_valid = 0;
    chk("t3_dropped", inst_valid, 0);
    chk("t3_req_valid", imem_req_valid, 1);
    chk("t3_req_addr", imem_req_addr, 32'h8000_0100);

    // 4: redirect coincident with request handshake, then with inst_ready
    imem_req_ready = 1; redir(32'h8000_0200); imem_req_ready = 0;
    chk("t4_wait_kill", imem_req_valid, 0);
    imem_rsp_valid = 1; imem_rsp_data = 32'h1111_1111; step(); imem_rsp_valid = 0;
    chk("t4_dropped", inst_valid, 0);
    chk("t4_req_addr", imem_req_addr, 32'h8000_0200);
    imem_req_ready = 1; step(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_2003; step(); imem_rsp_valid = 0;
    chk("t4_inst_valid", inst_valid, 1);
    chk("t4_inst_pc", inst_pc, 32'h8000_0200);
    chk("t4_pattern", inst_pattern, 8'h40);
    inst_ready = 1; redir(32'h8000_0200); inst_ready = 0;
    chk("t4_redir_req", imem_req_valid, 1);
    chk("t4_redir_addr", imem_req_addr, 32'h8000_0200);

    // 5: access fault and misaligned redirect
    imem_req_ready = 1; step(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_err = 1; step(); imem_rsp_valid = 0; imem_rsp_err = 0;
    chk("t5_fault", fetch_fault, 1);
    chk("t5_no_inst", inst_valid, 0);
    step(); step();
    chk("t5_fault_sticky", fetch_fault, 1);
    chk("t5_no_req", imem_req_valid, 0);
    redir(32'h8000_0000);
    chk("t5_fault_clear", fetch_fault, 0);
    chk("t5_refetch", imem_req_valid, 1);
    chk("t5_refetch_addr", imem_req_addr, 32'h8000_0000);
    redir(32'h8000_0002);
    chk("t5_misalign_fault", fetch_fault, 1);
    chk("t5_misalign_noreq", imem_req_valid, 0);

    // 6: PC wrap, then async reset mid-WAIT
    redir(32'hFFFF_FFFC);
    chk("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1; step(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013; step(); imem_rsp_valid = 0;
    chk("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1; step(); inst_ready = 0;
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    imem_req_ready = 1; step(); imem_req_ready = 0;
    chk("t6_in_wait", imem_req_valid, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("t6_rst_req", imem_req_valid, 1);
    chk("t6_rst_addr", imem_req_addr, 32'h8000_0000);
    chk("t6_rst_inst_pc", inst_pc, 0);
    chk("t6_rst_valid", inst_valid, 0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("t6_post_req", imem_req_valid, 1);
    chk("t6_post_addr", imem_req_addr, 32'h8000_0000);

    // misaligned redirect with a request in flight: response absorbed in FAULT
    imem_req_ready = 1; step(); imem_req_ready = 0;
    redir(32'h8000_0006);
    chk("t7_fault", fetch_fault, 1);
    imem_rsp_valid = 1; imem_rsp_data = 32'h2222_2222; step(); imem_rsp_valid = 0;
    chk("t7_fault_hold", fetch_fault, 1);
    chk("t7_no_inst", inst_valid, 0);
    redir(32'h8000_0010);
    chk("t7_req_valid", imem_req_valid, 1);
    chk("t7_req_addr", imem_req_addr, 32'h8000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
